msi_mem_ctrl: RTL and testbench
===============================

# msi_mem_ctrl

Memory-side controller directly downstream of the two-thread MSI snooping coherence controller. It consumes the bus transactions that controller produces: read miss, write miss, invalidate, write-back block, write-back cache block and abort memory access. It serves them against a small internal block memory with fixed access latency, then returns one fill per miss to the requesting thread. It also keeps saturating counters of aborted accesses and invalidates for the board display.

## Interface
- ADDR_W, 4, block address width (memory depth 2^ADDR_W)
- DATA_W, 8, block data width
- MEM_LAT, 3, cycles per memory read or write; legal range 1..15

- clock  in  1  single clock, rising edge
- resetn  in  1  reset, synchronous, active-low
- bus_valid  in  1  transaction present this cycle
- bus_ready  out  1  controller idle; a transaction is accepted on an edge where bus_valid && bus_ready
- read_miss, write_miss, invalidate  in  1 each  bus request flags
- wb_block, wb_cache, mem_abort  in  1 each  write-back and abort flags
- req_thread  in  1  requesting thread (0/1)
- addr  in  ADDR_W  requested block
- wb_addr  in  ADDR_W  victim block address (victim write-back only)
- wb_data  in  DATA_W  block data supplied by the writing-back cache
- fill_valid  out  1  one-cycle fill pulse
- fill_thread  out  1  thread receiving the fill
- fill_addr  out  ADDR_W  filled block
- fill_data  out  DATA_W  filled data
- abort_count  out  8  accepted aborted accesses, saturates at 255
- inv_count  out  8  accepted pure invalidates, saturates at 255

## Operation
- All inputs are latched on the accept edge. Inputs are ignored while bus_ready=0; upstream holds the request until it is accepted.
- Classification at accept, first matching rule wins:
  1. miss = read_miss|write_miss. If miss && wb_block && mem_abort → OWNER: write wb_data to mem[addr], fill with wb_data, skip the read, abort_count+1.
  2. (wb_cache | (wb_block & !mem_abort)) → VICTIM: write wb_data to mem[wb_addr], then read mem[addr], then fill. This applies with or without a miss flag.
  3. miss → READ: read mem[addr], then fill.
  4. invalidate alone → no memory access, no fill, inv_count+1, bus_ready stays 1.
  5. Nothing set, or mem_abort without wb_block → ignored, no state change.
- read_miss and write_miss both set are treated as a single miss.
- FSM states:
  - IDLE
  - WB: MEM_LAT cycles; memory write on the last WB edge
  - RD: MEM_LAT cycles; data sampled on the last RD edge
  - FILL: 1 cycle
- Transitions:
  - OWNER: IDLE→WB→FILL
  - VICTIM: IDLE→WB→RD→FILL
  - READ: IDLE→RD→FILL
  - FILL→IDLE
- A single down-counter of width 4 loads MEM_LAT-1 on entry to WB or RD and advances state at 0.
- Fill outputs hold the latched req_thread and addr. fill_data holds the RD result, or wb_data for OWNER. The fill outputs keep their last value after the pulse.
- VICTIM with wb_addr==addr: RD returns the newly written wb_data.

## Timing
- Reset (resetn=0 at an edge), from any state:
  - State → IDLE, bus_ready=1.
  - fill_valid=0, fill_thread=0, fill_addr=0, fill_data=0.
  - Both counters cleared.
  - All memory words cleared to 0.
  - Any transaction in flight is dropped with no fill.
- bus_ready falls in the cycle after the accept edge and rises in the cycle after FILL.
- Accept-to-fill_valid latency, counted in cycles after the accept edge:
  - READ and OWNER: fill_valid high in cycle MEM_LAT+1.
  - VICTIM: fill_valid high in cycle 2·MEM_LAT+1.
- Back-to-back throughput: the next accept occurs at the earliest on the edge ending the FILL cycle + 1.
- fill_valid is high for exactly one cycle per miss. Pure invalidates never produce a fill.
- Counters update on the accept edge and stay at 255 once saturated.

## Test plan
- Reset, then READ thread0 addr=5 (MEM_LAT=3) → fill_valid in cycle 4, fill_thread=0, fill_addr=5, fill_data=0x00; bus_ready low for cycles 1–4.
- VICTIM write_miss+wb_cache thread1 addr=2, wb_addr=2, wb_data=0xA5 → fill in cycle 7 with fill_data=0xA5; a following READ of addr 2 returns 0xA5.
- OWNER read_miss+wb_block+mem_abort thread0 addr=9, wb_data=0x3C → fill in cycle 4 with 0x3C, abort_count=1; a later READ of addr 9 returns 0x3C.
- 3 pure invalidates, then 300 OWNER transactions → inv_count=3, no fill pulses for the invalidates, bus_ready never drops for them; abort_count=255.
- bus_valid held high with a different request while busy → only the first is served; the second is accepted the cycle after FILL.
- resetn=0 during RD of a READ → no fill_valid, bus_ready=1 after reset, memory and counters zero.

Source files
------------

// File: rtl/msi_mem_ctrl_if.sv
// msi_mem_ctrl_if
// Bus-side bundle between the MSI snooping controller (master) and the
// memory-side controller (slave).
//   request : bus_valid, read_miss, write_miss, invalidate, wb_block, wb_cache,
//             mem_abort, req_thread, addr, wb_addr, wb_data
//   response: bus_ready, fill_valid, fill_thread, fill_addr, fill_data,
//             abort_count, inv_count
interface msi_mem_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              bus_valid;
  logic              bus_ready;
  logic              read_miss;
  logic              write_miss;
  logic              invalidate;
  logic              wb_block;
  logic              wb_cache;
  logic              mem_abort;
  logic              req_thread;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              fill_valid;
  logic              fill_thread;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;
  logic [7:0]        abort_count;
  logic [7:0]        inv_count;

  modport master (
    output bus_valid, read_miss, write_miss, invalidate, wb_block, wb_cache,
           mem_abort, req_thread, addr, wb_addr, wb_data,
    input  bus_ready, fill_valid, fill_thread, fill_addr, fill_data,
           abort_count, inv_count
  );

  modport slave (
    input  bus_valid, read_miss, write_miss, invalidate, wb_block, wb_cache,
           mem_abort, req_thread, addr, wb_addr, wb_data,
    output bus_ready, fill_valid, fill_thread, fill_addr, fill_data,
           abort_count, inv_count
  );
endinterface

// File: rtl/msi_mem_ctrl.sv
// msi_mem_ctrl
// Memory-side controller behind the two-thread MSI snooping controller.
// Serves read misses, victim write-backs and owner write-backs against a
// small block memory with fixed latency and returns one fill per miss.
// Ports:
//   clock  : rising-edge clock
//   resetn : synchronous active-low reset (clears FSM, fill outputs,
//            counters and the whole memory)
//   bus    : msi_mem_ctrl_if.slave (request flags in, fill/counters out)
//
// state | meaning
// IDLE  | ready for a transaction (bus_ready=1)
// WB    | MEM_LAT cycles, memory write on the last edge
// RD    | MEM_LAT cycles, memory read on the last edge
// FILL  | one-cycle fill pulse
module msi_mem_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 3
) (
  input logic           clock,
  input logic           resetn,
  msi_mem_ctrl_if.slave bus
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
  localparam int         DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, WB, RD, FILL} state_t;

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              load_cnt;
  logic              ready;
  logic              fill_pulse;

  logic              owner_q;
  logic              thr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              fill_thread_q;
  logic [ADDR_W-1:0] fill_addr_q;
  logic [DATA_W-1:0] fill_data_q;
  logic [7:0]        abort_q;
  logic [7:0]        inv_q;

  logic miss, is_owner, is_victim, is_read, is_inv, accept;
  logic wb_last, rd_last;

  // Classification, first matching rule wins.
  assign miss      = bus.read_miss | bus.write_miss;
  assign is_owner  = miss & bus.wb_block & bus.mem_abort;
  assign is_victim = ~is_owner & (bus.wb_cache | (bus.wb_block & ~bus.mem_abort));
  assign is_read   = ~is_owner & ~is_victim & miss;
  // A pure invalidate carries no other flag at all.
  assign is_inv    = bus.invalidate & ~miss & ~bus.wb_cache & ~bus.wb_block & ~bus.mem_abort;
  assign accept    = bus.bus_valid & ready;

  assign wb_last = (state == WB) && (cnt == 4'd0);
  assign rd_last = (state == RD) && (cnt == 4'd0);

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    fill_pulse = 1'b0;
    load_cnt   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (accept) begin
          if (is_owner || is_victim) begin
            state_nxt = WB;
            load_cnt  = 1'b1;
          end else if (is_read) begin
            state_nxt = RD;
            load_cnt  = 1'b1;
          end
        end
      end
      WB: begin
        if (cnt == 4'd0) begin
          if (owner_q) begin
            state_nxt = FILL;
          end else begin
            state_nxt = RD;
            load_cnt  = 1'b1;
          end
        end
      end
      RD: begin
        if (cnt == 4'd0) state_nxt = FILL;
      end
      FILL: begin
        fill_pulse = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn)                cnt <= 4'd0;
    else if (load_cnt)          cnt <= LAT_M1;
    else if (cnt != 4'd0)       cnt <= cnt - 4'd1;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      owner_q       <= 1'b0;
      thr_q         <= 1'b0;
      addr_q        <= '0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      fill_thread_q <= 1'b0;
      fill_addr_q   <= '0;
      fill_data_q   <= '0;
      abort_q       <= 8'd0;
      inv_q         <= 8'd0;
      for (int i = 0; i < DEPTH; i++) mem[ADDR_W'(i)] <= '0;
    end else begin
      if (accept && (is_owner || is_victim || is_read)) begin
        owner_q   <= is_owner;
        thr_q     <= bus.req_thread;
        addr_q    <= bus.addr;
        wb_addr_q <= bus.wb_addr;
        wb_data_q <= bus.wb_data;
      end
      if (accept && is_owner && (abort_q != 8'hFF)) abort_q <= abort_q + 8'd1;
      if (accept && is_inv   && (inv_q   != 8'hFF)) inv_q   <= inv_q + 8'd1;

      // Owner write-back lands on the requested block and is forwarded
      // straight to the fill; a victim goes to its own address.
      if (wb_last) begin
        mem[owner_q ? addr_q : wb_addr_q] <= wb_data_q;
        if (owner_q) begin
          fill_thread_q <= thr_q;
          fill_addr_q   <= addr_q;
          fill_data_q   <= wb_data_q;
        end
      end
      if (rd_last) begin
        fill_thread_q <= thr_q;
        fill_addr_q   <= addr_q;
        fill_data_q   <= mem[addr_q];
      end
    end
  end

  assign bus.bus_ready   = ready;
  assign bus.fill_valid  = fill_pulse;
  assign bus.fill_thread = fill_thread_q;
  assign bus.fill_addr   = fill_addr_q;
  assign bus.fill_data   = fill_data_q;
  assign bus.abort_count = abort_q;
  assign bus.inv_count   = inv_q;

endmodule

// File: tb/tb_msi_mem_ctrl.sv
module tb_msi_mem_ctrl;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int LAT = 3;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  msi_mem_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

  msi_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bif)
  );

  typedef struct {
    logic          thr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            cyc;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_acc;
  exp_t sbq[$];

  logic [DW-1:0] ref_mem [16];
  int            ref_abort;
  int            ref_inv;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every fill pulse is matched against the oldest expectation.
  always @(negedge clock) begin
    exp_t e;
    if (resetn && bif.fill_valid) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_fill: got fill addr=%0d expected none (cycle %0d)",
                 bif.fill_addr, cyc);
      end else begin
        e = sbq.pop_front();
        check("fill_thread", int'(bif.fill_thread), int'(e.thr));
        check("fill_addr",   int'(bif.fill_addr),   int'(e.a));
        check("fill_data",   int'(bif.fill_data),   int'(e.d));
        check("fill_cycle",  cyc,                   e.cyc);
      end
    end
  end

  task automatic idle_inputs();
    bif.bus_valid  = 1'b0;
    bif.read_miss  = 1'b0;
    bif.write_miss = 1'b0;
    bif.invalidate = 1'b0;
    bif.wb_block   = 1'b0;
    bif.wb_cache   = 1'b0;
    bif.mem_abort  = 1'b0;
    bif.req_thread = 1'b0;
    bif.addr       = '0;
    bif.wb_addr    = '0;
    bif.wb_data    = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    ref_abort = 0;
    ref_inv   = 0;
    sbq.delete();
  endtask

  // Entered and left at a negedge. Holds the request until accepted.
  task automatic send(input logic rm, input logic wm, input logic inv,
                      input logic wbb, input logic wbc, input logic ab,
                      input logic thr, input logic [AW-1:0] a,
                      input logic [AW-1:0] wa, input logic [DW-1:0] d);
    int   t;
    int   lat;
    bit   miss, own, vic, rd, pinv;
    exp_t e;
    bif.bus_valid  = 1'b1;
    bif.read_miss  = rm;
    bif.write_miss = wm;
    bif.invalidate = inv;
    bif.wb_block   = wbb;
    bif.wb_cache   = wbc;
    bif.mem_abort  = ab;
    bif.req_thread = thr;
    bif.addr       = a;
    bif.wb_addr    = wa;
    bif.wb_data    = d;
    t = 0;
    while (!bif.bus_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (!bif.bus_ready) begin
      check("accept_timeout", 0, 1);
      bif.bus_valid = 1'b0;
      return;
    end
    last_acc = cyc;
    miss = rm | wm;
    own  = miss && wbb && ab;
    vic  = !own && (wbc || (wbb && !ab));
    rd   = !own && !vic && miss;
    pinv = inv && !miss && !wbb && !wbc && !ab;
    lat  = 0;
    e.thr = thr;
    e.a   = a;
    e.d   = '0;
    if (own) begin
      ref_mem[a] = d;
      e.d = d;
      lat = LAT + 1;
      if (ref_abort < 255) ref_abort++;
    end else if (vic) begin
      ref_mem[wa] = d;
      e.d = ref_mem[a];
      lat = 2 * LAT + 1;
    end else if (rd) begin
      e.d = ref_mem[a];
      lat = LAT + 1;
    end else if (pinv) begin
      if (ref_inv < 255) ref_inv++;
    end
    e.cyc = last_acc + lat;
    if (own || vic || rd) sbq.push_back(e);
    @(posedge clock);
    @(negedge clock);
    bif.bus_valid = 1'b0;
    check("ready_after_accept", int'(bif.bus_ready), (own || vic || rd) ? 0 : 1);
    check("abort_count", int'(bif.abort_count), ref_abort);
    check("inv_count",   int'(bif.inv_count),   ref_inv);
  endtask

  task automatic check_reset_state();
    check("rst_bus_ready",   int'(bif.bus_ready),   1);
    check("rst_fill_valid",  int'(bif.fill_valid),  0);
    check("rst_fill_thread", int'(bif.fill_thread), 0);
    check("rst_fill_addr",   int'(bif.fill_addr),   0);
    check("rst_fill_data",   int'(bif.fill_data),   0);
    check("rst_abort_count", int'(bif.abort_count), 0);
    check("rst_inv_count",   int'(bif.inv_count),   0);
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    model_clear();
    check_reset_state();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("queue_drain", sbq.size(), 0);
  endtask

  initial begin
    int acc_a;
    logic [5:0] f;
    idle_inputs();
    model_clear();
    @(negedge clock);
    do_reset();

    // READ from cleared memory
    send(1, 0, 0, 0, 0, 0, 1'b0, 4'd5, 4'd0, 8'h00);
    // VICTIM onto the same block, then read it back
    send(0, 1, 0, 0, 1, 0, 1'b1, 4'd2, 4'd2, 8'hA5);
    send(1, 0, 0, 0, 0, 0, 1'b0, 4'd2, 4'd0, 8'h00);
    // OWNER write-back forwarded to fill, then read back
    send(1, 0, 0, 1, 0, 1, 1'b0, 4'd9, 4'd0, 8'h3C);
    send(1, 0, 0, 0, 0, 0, 1'b1, 4'd9, 4'd0, 8'h00);
    // VICTIM with distinct addresses, both miss flags set
    send(1, 1, 0, 1, 0, 0, 1'b1, 4'd7, 4'd4, 8'h5A);
    send(0, 1, 0, 0, 0, 0, 1'b0, 4'd4, 4'd0, 8'h00);
    // Request held high while busy: second accepted the cycle after FILL
    send(1, 0, 0, 0, 0, 0, 1'b0, 4'd3, 4'd0, 8'h00);
    acc_a = last_acc;
    send(1, 0, 0, 0, 0, 0, 1'b1, 4'd9, 4'd0, 8'h00);
    check("held_accept_gap", last_acc - acc_a, LAT + 2);
    drain();

    // Randomized mix of every flag combination
    for (int i = 0; i < 150; i++) begin
      f = 6'($urandom);
      send(f[0], f[1], f[2], f[3], f[4], f[5], 1'($urandom),
           4'($urandom), 4'($urandom), 8'($urandom));
    end
    drain();

    // Reset while a READ sits in RD: dropped with no fill
    send(1, 0, 0, 0, 0, 0, 1'b1, 4'd6, 4'd0, 8'h00);
    @(negedge clock);
    do_reset();
    repeat (8) @(negedge clock);
    check("no_fill_after_reset", sbq.size(), 0);
    send(0, 1, 0, 0, 1, 0, 1'b0, 4'd1, 4'd1, 8'hC3);
    send(1, 0, 0, 0, 0, 0, 1'b0, 4'd2, 4'd0, 8'h00);
    send(1, 0, 0, 0, 0, 0, 1'b1, 4'd9, 4'd0, 8'h00);
    drain();

    // Pure invalidates then abort-counter saturation
    for (int i = 0; i < 3; i++)
      send(0, 0, 1, 0, 0, 0, 1'b0, 4'($urandom), 4'd0, 8'h00);
    for (int i = 0; i < 300; i++)
      send(1, 0, 0, 1, 0, 1, 1'($urandom), 4'($urandom), 4'd0, 8'($urandom));
    drain();
    check("final_inv_count",   int'(bif.inv_count),   3);
    check("final_abort_count", int'(bif.abort_count), 255);

    repeat (4) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
